// File: rtl/inst_fetch_axi.sv
// Instruction fetch unit: issues one AXI read per instruction and hands the
// word to the IF/ID register. It handles delayed-slot branch redirects and
// exception flushes, and drains any read that is still in flight.
module inst_fetch_axi (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        inst_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        inst_valid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_HOLD} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   araddr_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              inst_valid_q;
  logic [XLEN-1:0]   if_pc_q;
  logic [XLEN-1:0]   if_inst_q;
  logic              flush_pend_q;
  logic [XLEN-1:0]   flush_addr_q;
  logic              br_pend_q;
  logic [XLEN-1:0]   br_addr_q;
  logic              discard_q;

  logic              branch_take_d;
  logic [XLEN-1:0]   accept_pc_d;
  logic [XLEN-1:0]   redirect_pc_d;
  logic [XLEN-1:0]   rd_word_d;

  // Only stall bits 1 and 2 matter to the fetch stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[0]};

  // Next-pc selection, flush redirect target and error-masked read word.
  always_comb begin
    branch_take_d = branch_flag && !stall[2] && !flush;
    accept_pc_d   = pc_q + PC_STEP;
    if (flush_pend_q) begin
      accept_pc_d = flush_addr_q;
    end else if (branch_take_d) begin
      accept_pc_d = branch_target;
    end else if (br_pend_q) begin
      accept_pc_d = br_addr_q;
    end
    redirect_pc_d = flush ? new_pc : flush_addr_q;
    rd_word_d     = (rresp == 2'b00) ? rdata : '0;
  end

  // Fetch FSM with registered bus and delivery outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      if_pc_q      <= '0;
      if_inst_q    <= '0;
      flush_pend_q <= 1'b0;
      flush_addr_q <= '0;
      br_pend_q    <= 1'b0;
      br_addr_q    <= '0;
      discard_q    <= 1'b0;
    end else begin
      if (flush) begin
        br_pend_q <= 1'b0;
      end else if (branch_take_d) begin
        br_pend_q <= 1'b1;
        br_addr_q <= branch_target;
      end

      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            pc_q      <= new_pc;
            araddr_q  <= new_pc;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end else if (inst_ready) begin
            araddr_q  <= pc_q;
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          // The address phase is never abandoned; a flush only marks the
          // read for discard.
          if (flush) begin
            flush_pend_q <= 1'b1;
            flush_addr_q <= new_pc;
            discard_q    <= 1'b1;
          end
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            if (discard_q || flush) begin
              pc_q         <= redirect_pc_d;
              araddr_q     <= redirect_pc_d;
              arvalid_q    <= 1'b1;
              flush_pend_q <= 1'b0;
              discard_q    <= 1'b0;
              state_q      <= ST_ADDR;
            end else begin
              inst_valid_q <= 1'b1;
              if_pc_q      <= pc_q;
              if_inst_q    <= rd_word_d;
              state_q      <= ST_HOLD;
            end
          end else if (flush) begin
            flush_pend_q <= 1'b1;
            flush_addr_q <= new_pc;
            discard_q    <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (flush) begin
            inst_valid_q <= 1'b0;
            if_pc_q      <= '0;
            if_inst_q    <= '0;
            pc_q         <= new_pc;
            araddr_q     <= new_pc;
            arvalid_q    <= 1'b1;
            state_q      <= ST_ADDR;
          end else if (!stall[1]) begin
            inst_valid_q <= 1'b0;
            if_pc_q      <= '0;
            if_inst_q    <= '0;
            pc_q         <= accept_pc_d;
            araddr_q     <= accept_pc_d;
            arvalid_q    <= 1'b1;
            flush_pend_q <= 1'b0;
            br_pend_q    <= 1'b0;
            state_q      <= ST_ADDR;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign inst_valid = inst_valid_q;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;

endmodule

// File: doc/inst_fetch_axi.md
INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

Interface
REQ-001 Reset is rst, synchronous, active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 stall  in  6  pipeline stall vector from the pipeline controller; bit1=1 means the IF/ID register holds.
REQ-005 flush  in  1  exception flush, one-cycle pulse.
REQ-006 new_pc  in  32  exception handler address, valid while flush=1.
REQ-007 branch_flag  in  1  taken-branch pulse from decode.
REQ-008 branch_target  in  32  branch destination, valid while branch_flag=1.
REQ-009 inst_ready  in  1  IF/ID register able to accept.
REQ-010 if_pc  out  32  address of the delivered instruction.
REQ-011 if_inst  out  32  delivered instruction word.
REQ-012 inst_valid  out  1  if_pc/if_inst valid this cycle.
REQ-013 araddr  out  32  AXI read address.
REQ-014 arvalid  out  1  AXI read-address valid.
REQ-015 arready  in  1  AXI read-address ready.
REQ-016 rdata  in  32  AXI read data.
REQ-017 rresp  in  2  AXI read response.
REQ-018 rvalid  in  1  AXI read-data valid.
REQ-019 rready  out  1  AXI read-data ready.

Function
REQ-020 The FSM SHALL have four states: IDLE, ADDR, DATA and HOLD.
REQ-021 IDLE: arvalid=0 and rready=0; the FSM SHALL move to ADDR on the next cycle when rst=0 and inst_ready=1.
REQ-022 ADDR: arvalid=1 and araddr=pc, both held stable until the cycle arready=1; the FSM SHALL then move to DATA.
REQ-023 DATA: rready=1; on rvalid=1 the block SHALL capture rdata (or 0x00000000 when rresp!=2'b00) and move to HOLD, unless a discard is pending.
REQ-024 HOLD: inst_valid=1, if_pc=pc, if_inst=captured word; the FSM SHALL leave HOLD only in a cycle with stall[1]=0, which is the acceptance cycle.
REQ-025 On acceptance the block SHALL load pc with the next pc and return to ADDR.
REQ-026 Next pc priority: pending flush address, then pending branch target, then pc+4 (mod 2^32, wraps 0xFFFFFFFC->0x00000000).
REQ-027 branch_flag=1 with stall[2]=0 SHALL latch branch_target into a pending-redirect register, applied at the next acceptance; the instruction already in flight is the delay slot and SHALL be delivered.
REQ-028 flush=1 in any state SHALL latch new_pc as pending-flush, clear any pending branch and force inst_valid=0 from the next cycle.
REQ-029 If flush hits in ADDR before arready or in DATA, the outstanding AXI transaction SHALL be completed, its data discarded, then pc=new_pc and the FSM goes to ADDR.
REQ-030 If flush hits in HOLD or IDLE, pc SHALL become new_pc next cycle and the FSM goes to ADDR.
REQ-031 Flush and branch_flag in the same cycle: flush SHALL win and the branch SHALL be dropped.
REQ-032 arvalid SHALL never deassert before arready, and at most one read SHALL be outstanding.
REQ-033 inst_valid=0 in IDLE, ADDR and DATA; if_pc and if_inst SHALL be 0 whenever inst_valid=0.
REQ-034 stall[1]=1 in ADDR or DATA SHALL NOT stall the AXI handshake; it only delays leaving HOLD.

Reset
REQ-035 With rst=1 at a clock edge: pc=0xBFC00000, FSM=IDLE, arvalid=0, rready=0, inst_valid=0, if_pc=0, if_inst=0, araddr=0, pending flags cleared.
REQ-036 Reset SHALL abandon any in-flight AXI transaction; the bench SHALL also reset the AXI slave.

Verification
REQ-037 Release reset, slave arready=1 immediately, rvalid one cycle later with 0x24080001, stall=0 -> araddr=0xBFC00000; inst_valid=1 with if_pc=0xBFC00000 and if_inst=0x24080001; next araddr=0xBFC00004.
REQ-038 Slave holds arready=0 for 3 cycles -> arvalid=1 and araddr unchanged all 3 cycles; exactly one AR handshake.
REQ-039 stall[1]=1 for 4 cycles while in HOLD -> inst_valid, if_pc and if_inst stable for 4 cycles; no new arvalid until stall[1]=0.
REQ-040 branch_flag=1 with target 0x80000100 while pc=0xBFC00008 is in flight -> 0xBFC00008 delivered, next fetch araddr=0x80000100.
REQ-041 flush=1 with new_pc=0xBFC00380 during DATA -> rvalid data dropped (no inst_valid), next araddr=0xBFC00380.
REQ-042 rresp=2'b10 on a read -> if_inst=0x00000000 with inst_valid=1 and pc advanced by 4.
